// File: rtl/ldpc_min_sum_tree_20.sv
// rtl/ldpc_min_sum_tree_20.sv - pipelined 20-input two-minimum finder for the LDPC check node
//
// Finds min1, min2 and the index of min1 across x0..x19 with a 2-min merge tree:
// 20 leaves -> 10 -> 5 (registered) -> 3 -> 2 -> 1 (registered). Two clocks of latency,
// one vector per clock, no back-pressure.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid, x0..x19   input vector strobe and magnitudes (xK has index K)
//   out_valid           result strobe, two clocks after in_valid
//   min1, min2          smallest and second-smallest magnitude (multiset sense)
//   min1_index          lowest index carrying min1
module ldpc_min_sum_tree_20 #(
  parameter int MAG_W = 5,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [MAG_W-1:0] x0,
  input  logic [MAG_W-1:0] x1,
  input  logic [MAG_W-1:0] x2,
  input  logic [MAG_W-1:0] x3,
  input  logic [MAG_W-1:0] x4,
  input  logic [MAG_W-1:0] x5,
  input  logic [MAG_W-1:0] x6,
  input  logic [MAG_W-1:0] x7,
  input  logic [MAG_W-1:0] x8,
  input  logic [MAG_W-1:0] x9,
  input  logic [MAG_W-1:0] x10,
  input  logic [MAG_W-1:0] x11,
  input  logic [MAG_W-1:0] x12,
  input  logic [MAG_W-1:0] x13,
  input  logic [MAG_W-1:0] x14,
  input  logic [MAG_W-1:0] x15,
  input  logic [MAG_W-1:0] x16,
  input  logic [MAG_W-1:0] x17,
  input  logic [MAG_W-1:0] x18,
  input  logic [MAG_W-1:0] x19,
  output logic             out_valid,
  output logic [MAG_W-1:0] min1,
  output logic [MAG_W-1:0] min2,
  output logic [IDX_W-1:0] min1_index
);

  typedef struct packed {
    logic [MAG_W-1:0] m1;
    logic [MAG_W-1:0] m2;
    logic [IDX_W-1:0] idx;
  } node_t;

  // Leaf: on a tie the left (lower-index) input wins.
  function automatic node_t leaf(input logic [MAG_W-1:0] a, input logic [MAG_W-1:0] b,
                                 input logic [IDX_W-1:0] ia, input logic [IDX_W-1:0] ib);
    node_t n;
    if (b < a) begin
      n.m1 = b; n.m2 = a; n.idx = ib;
    end else begin
      n.m1 = a; n.m2 = b; n.idx = ia;
    end
    return n;
  endfunction

  // Merge: a always covers lower indices than b, so the strict compare keeps the
  // lowest index on ties and lets a duplicated minimum land in min2.
  function automatic node_t merge(input node_t a, input node_t b);
    node_t n;
    if (b.m1 < a.m1) begin
      n.m1  = b.m1;
      n.idx = b.idx;
      n.m2  = (a.m1 < b.m2) ? a.m1 : b.m2;
    end else begin
      n.m1  = a.m1;
      n.idx = a.idx;
      n.m2  = (b.m1 < a.m2) ? b.m1 : a.m2;
    end
    return n;
  endfunction

  logic [MAG_W-1:0] x [20];
  assign x[0]  = x0;  assign x[1]  = x1;  assign x[2]  = x2;  assign x[3]  = x3;
  assign x[4]  = x4;  assign x[5]  = x5;  assign x[6]  = x6;  assign x[7]  = x7;
  assign x[8]  = x8;  assign x[9]  = x9;  assign x[10] = x10; assign x[11] = x11;
  assign x[12] = x12; assign x[13] = x13; assign x[14] = x14; assign x[15] = x15;
  assign x[16] = x16; assign x[17] = x17; assign x[18] = x18; assign x[19] = x19;

  node_t lvl10 [10];
  node_t lvl5  [5];
  node_t s1    [5];
  logic  s1_valid;
  node_t lvl3  [3];
  node_t lvl2  [2];
  node_t root;

  always_comb begin
    for (int i = 0; i < 10; i++) begin
      lvl10[i] = leaf(x[2*i], x[2*i+1], IDX_W'(2*i), IDX_W'(2*i+1));
    end
    for (int i = 0; i < 5; i++) begin
      lvl5[i] = merge(lvl10[2*i], lvl10[2*i+1]);
    end
  end

  // First register bank after the 10->5 level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < 5; i++) s1[i] <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 5; i++) s1[i] <= lvl5[i];
      end
    end
  end

  // Odd nodes (s1[4], then lvl3[2]) ride through unchanged; they always hold the
  // highest indices so they stay on the b side of every merge.
  always_comb begin
    lvl3[0] = merge(s1[0], s1[1]);
    lvl3[1] = merge(s1[2], s1[3]);
    lvl3[2] = s1[4];
    lvl2[0] = merge(lvl3[0], lvl3[1]);
    lvl2[1] = lvl3[2];
    root    = merge(lvl2[0], lvl2[1]);
  end

  // Output register; results hold while no new vector arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      min1       <= '0;
      min2       <= '0;
      min1_index <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        min1       <= root.m1;
        min2       <= root.m2;
        min1_index <= root.idx;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_min_sum_tree_20.sv
// tb/tb_ldpc_min_sum_tree_20.sv - directed self-checking bench for ldpc_min_sum_tree_20
module tb_ldpc_min_sum_tree_20;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] xv [20];
  logic       out_valid;
  logic [4:0] min1;
  logic [4:0] min2;
  logic [4:0] min1_index;

  int tests_run;
  int tests_failed;

  logic [4:0] t1_base [19] = '{30, 12, 15, 18, 22, 19, 5, 7, 8, 9, 29, 16, 12, 11, 7, 8, 2, 1, 5};

  ldpc_min_sum_tree_20 #(.MAG_W(5), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .x0(xv[0]),   .x1(xv[1]),   .x2(xv[2]),   .x3(xv[3]),   .x4(xv[4]),
    .x5(xv[5]),   .x6(xv[6]),   .x7(xv[7]),   .x8(xv[8]),   .x9(xv[9]),
    .x10(xv[10]), .x11(xv[11]), .x12(xv[12]), .x13(xv[13]), .x14(xv[14]),
    .x15(xv[15]), .x16(xv[16]), .x17(xv[17]), .x18(xv[18]), .x19(xv[19]),
    .out_valid(out_valid), .min1(min1), .min2(min2), .min1_index(min1_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] e1,
                         input logic [4:0] e2, input logic [4:0] ei);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".min1"},  {27'd0, min1},       {27'd0, e1});
    chk({tag, ".min2"},  {27'd0, min2},       {27'd0, e2});
    chk({tag, ".idx"},   {27'd0, min1_index}, {27'd0, ei});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_t1(input logic [4:0] last);
    for (int i = 0; i < 19; i++) xv[i] = t1_base[i];
    xv[19] = last;
  endtask

  task automatic set_all(input logic [4:0] v);
    for (int i = 0; i < 20; i++) xv[i] = v;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    in_valid     = 1'b0;
    set_all(5'd0);
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_out("reset", 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset.valid", {31'd0, out_valid}, 32'd0);

    // T1 with latency probe
    set_t1(5'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_latency1.valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_out("t1", 1'b1, 5'd0, 5'd1, 5'd19);
    tick();
    chk_out("t1_hold", 1'b0, 5'd0, 5'd1, 5'd19);

    // T2
    set_t1(5'd31);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("t2", 1'b1, 5'd1, 5'd2, 5'd17);

    // T3: all equal
    set_all(5'd7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("t3_all7", 1'b1, 5'd7, 5'd7, 5'd0);

    // T3b: duplicated minimum at x3 and x12
    set_all(5'd20);
    xv[3] = 5'd4; xv[12] = 5'd4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("t3_dup4", 1'b1, 5'd4, 5'd4, 5'd3);

    // T4: back-to-back T1, T2, T3
    set_t1(5'd0);
    in_valid = 1'b1;
    tick();
    set_t1(5'd31);
    tick();
    chk_out("t4_a", 1'b1, 5'd0, 5'd1, 5'd19);
    set_all(5'd7);
    tick();
    chk_out("t4_b", 1'b1, 5'd1, 5'd2, 5'd17);
    in_valid = 1'b0;
    tick();
    chk_out("t4_c", 1'b1, 5'd7, 5'd7, 5'd0);
    tick();
    chk("t4_end.valid", {31'd0, out_valid}, 32'd0);

    // T5: minimum at the far pass-through end
    set_all(5'd31);
    xv[19] = 5'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("t5_last", 1'b1, 5'd0, 5'd31, 5'd19);

    // T5b: ramp xK = K
    for (int i = 0; i < 20; i++) xv[i] = 5'(i);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("t5_ramp", 1'b1, 5'd0, 5'd1, 5'd0);

    // T6: reset while results are in flight
    set_t1(5'd0);
    in_valid = 1'b1;
    tick();
    set_t1(5'd31);
    tick();
    in_valid = 1'b0;
    chk("t6_pre.valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("t6_async", 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_quiet.valid", {31'd0, out_valid}, 32'd0);
    end
    set_all(5'd20);
    xv[3] = 5'd4; xv[12] = 5'd4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t6_new_lat1.valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_out("t6_new", 1'b1, 5'd4, 5'd4, 5'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
